// File: rtl/mii_frame_generator.sv
// MII frame generator for PCS/encoder bring-up benches.
// Emits repeating frames on a TX MII bus: idle beats, a start/preamble beat,
// a configurable number of payload beats, then a terminate beat. Control is
// per byte lane (lane 0 = bits [7:0]).
//
// Ports:
//   clk            clock
//   i_rst          synchronous active-high reset
//   i_enable       1 = generate frames; 0 = finish the current frame, then idle
//   i_idle_len     idle beats before each frame (0 acts as 1)
//   i_data_len     payload beats per frame (0 acts as 1)
//   i_mode         0 incrementing byte, 1 fixed pattern, 2 LFSR, 3 same as 0
//   i_pattern      byte replicated on every lane in mode 1
//   i_max_frames   0 = unlimited, else stop after this many frames
//   o_tx_data      MII data
//   o_tx_ctrl      per-lane control flag, 1 = control character
//   o_frame_count  frames completed, saturating
//   o_done         sticky, set when the frame limit is reached
module mii_frame_generator #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic [LEN_WIDTH-1:0]    i_idle_len,
  input  logic [LEN_WIDTH-1:0]    i_data_len,
  input  logic [1:0]              i_mode,
  input  logic [7:0]              i_pattern,
  input  logic [CNT_WIDTH-1:0]    i_max_frames,
  output logic [DATA_WIDTH-1:0]   o_tx_data,
  output logic [DATA_WIDTH/8-1:0] o_tx_ctrl,
  output logic [CNT_WIDTH-1:0]    o_frame_count,
  output logic                    o_done
);

  localparam int unsigned Lanes  = DATA_WIDTH / 8;
  localparam int unsigned Slices = DATA_WIDTH / 32;

  localparam logic [DATA_WIDTH-1:0] IdleData  = {Lanes{8'h07}};
  localparam logic [DATA_WIDTH-1:0] StartData = {8'hD5, {(Lanes - 2){8'h55}}, 8'hFB};
  localparam logic [DATA_WIDTH-1:0] TermData  = {{(Lanes - 1){8'h07}}, 8'hFD};
  localparam logic [Lanes-1:0]      CtrlAll   = {Lanes{1'b1}};
  localparam logic [Lanes-1:0]      CtrlStart = {{(Lanes - 1){1'b0}}, 1'b1};

  localparam logic [LEN_WIDTH-1:0] LenOne  = LEN_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CntMax  = {CNT_WIDTH{1'b1}};
  localparam logic [7:0]           ByteInc = 8'(Lanes);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StTerm
  } state_e;

  state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    idle_cnt_q, idle_cnt_d;
  logic [LEN_WIDTH-1:0]    data_cnt_q, data_cnt_d;
  logic [7:0]              byte_cnt_q, byte_cnt_d;
  logic [31:0]             lfsr_q, lfsr_d;
  logic [CNT_WIDTH-1:0]    frame_cnt_q, frame_cnt_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic [Lanes-1:0]        tx_ctrl_q, tx_ctrl_d;

  // Configuration held for one idle gap plus the frame that follows it.
  // Lengths are stored already clamped to a minimum of 1.
  logic [LEN_WIDTH-1:0]    idle_len_q, data_len_q;
  logic [1:0]              mode_q;
  logic [7:0]              pattern_q;
  logic [LEN_WIDTH-1:0]    idle_len_in, data_len_in;

  logic                    idle_reached, data_reached;

  assign idle_len_in = (i_idle_len == '0) ? LenOne : i_idle_len;
  assign data_len_in = (i_data_len == '0) ? LenOne : i_data_len;

  // Counters never exceed len-1, so the +1 cannot overflow.
  assign idle_reached = (idle_cnt_q + LenOne) >= idle_len_q;
  assign data_reached = (data_cnt_q + LenOne) >= data_len_q;

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    data_cnt_d  = data_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    lfsr_d      = lfsr_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = done_q;
    unique case (state_q)
      StIdle: begin
        if (idle_reached) begin
          // Count stays saturated while waiting for enable.
          if (i_enable && !done_q) begin
            state_d = StStart;
          end
        end else begin
          idle_cnt_d = idle_cnt_q + LenOne;
        end
      end
      StStart: begin
        state_d    = StData;
        data_cnt_d = '0;
        byte_cnt_d = '0;
      end
      StData: begin
        byte_cnt_d = byte_cnt_q + ByteInc;
        // x^32 + x^22 + x^2 + x + 1, shifting towards the MSB
        lfsr_d     = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
        if (data_reached) begin
          state_d = StTerm;
        end else begin
          data_cnt_d = data_cnt_q + LenOne;
        end
      end
      StTerm: begin
        state_d     = StIdle;
        idle_cnt_d  = '0;
        frame_cnt_d = (frame_cnt_q == CntMax) ? frame_cnt_q : frame_cnt_q + CntOne;
        if ((i_max_frames != '0) && (frame_cnt_d == i_max_frames)) begin
          done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Beat for the current state, registered into the outputs
  always_comb begin
    tx_data_d = IdleData;
    tx_ctrl_d = CtrlAll;
    unique case (state_q)
      StIdle: begin
      end
      StStart: begin
        tx_data_d = StartData;
        tx_ctrl_d = CtrlStart;
      end
      StData: begin
        tx_ctrl_d = '0;
        unique case (mode_q)
          2'd1: tx_data_d = {Lanes{pattern_q}};
          2'd2: begin
            for (int j = 0; j < int'(Slices); j++) begin
              tx_data_d[32*j +: 32] = lfsr_q;
            end
          end
          default: begin
            for (int k = 0; k < int'(Lanes); k++) begin
              tx_data_d[8*k +: 8] = byte_cnt_q + 8'(k);
            end
          end
        endcase
      end
      StTerm: begin
        tx_data_d = TermData;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      idle_cnt_q  <= '0;
      data_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      lfsr_q      <= 32'hFFFF_FFFF;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
      tx_data_q   <= IdleData;
      tx_ctrl_q   <= CtrlAll;
      idle_len_q  <= idle_len_in;
      data_len_q  <= data_len_in;
      mode_q      <= i_mode;
      pattern_q   <= i_pattern;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      data_cnt_q  <= data_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      lfsr_q      <= lfsr_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
      tx_data_q   <= tx_data_d;
      tx_ctrl_q   <= tx_ctrl_d;
      // Re-sample configuration on the way back into idle
      if (state_q == StTerm) begin
        idle_len_q <= idle_len_in;
        data_len_q <= data_len_in;
        mode_q     <= i_mode;
        pattern_q  <= i_pattern;
      end
    end
  end

  assign o_tx_data     = tx_data_q;
  assign o_tx_ctrl     = tx_ctrl_q;
  assign o_frame_count = frame_cnt_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_mii_frame_generator.sv
// Scoreboard bench for mii_frame_generator: a 64-bit instance checked beat by
// beat against queued expectations, and a 128-bit instance sharing the same
// inputs whose control beats and first payload beat are checked by encoding.
module tb_mii_frame_generator;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_enable = 1'b0;
  logic [15:0] i_idle_len = 16'd1;
  logic [15:0] i_data_len = 16'd1;
  logic [1:0]  i_mode = 2'd0;
  logic [7:0]  i_pattern = 8'h00;
  logic [31:0] i_max_frames = 32'd0;

  logic [63:0]  tx_data64;
  logic [7:0]   tx_ctrl64;
  logic [31:0]  fc64;
  logic         done64;
  logic [127:0] tx_data128;
  logic [15:0]  tx_ctrl128;
  logic [31:0]  fc128;
  logic         done128;

  always #5 clk = ~clk;

  mii_frame_generator #(.DATA_WIDTH(64), .LEN_WIDTH(16), .CNT_WIDTH(32)) dut64 (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_enable     (i_enable),
    .i_idle_len   (i_idle_len),
    .i_data_len   (i_data_len),
    .i_mode       (i_mode),
    .i_pattern    (i_pattern),
    .i_max_frames (i_max_frames),
    .o_tx_data    (tx_data64),
    .o_tx_ctrl    (tx_ctrl64),
    .o_frame_count(fc64),
    .o_done       (done64)
  );

  mii_frame_generator #(.DATA_WIDTH(128), .LEN_WIDTH(16), .CNT_WIDTH(32)) dut128 (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_enable     (i_enable),
    .i_idle_len   (i_idle_len),
    .i_data_len   (i_data_len),
    .i_mode       (i_mode),
    .i_pattern    (i_pattern),
    .i_max_frames (i_max_frames),
    .o_tx_data    (tx_data128),
    .o_tx_ctrl    (tx_ctrl128),
    .o_frame_count(fc128),
    .o_done       (done128)
  );

  localparam logic [63:0]  IDLE64    = 64'h0707070707070707;
  localparam logic [63:0]  START64   = 64'hD5555555555555FB;
  localparam logic [63:0]  TERM64    = 64'h07070707070707FD;
  localparam logic [127:0] IDLE128   = {16{8'h07}};
  localparam logic [127:0] START128  = {8'hD5, {14{8'h55}}, 8'hFB};
  localparam logic [127:0] TERM128   = {{15{8'h07}}, 8'hFD};
  localparam logic [127:0] DATA128_0 = 128'h0F0E0D0C0B0A09080706050403020100;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  ctrl;
    int          gap;   // idle beats expected before this beat, -1 = unchecked
    int          cnt;   // frame count after this beat, -1 = unchecked
    int          dn;    // done after this beat
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   idle_run = 0;
  logic rst_edge = 1'b1;
  bit   first128 = 1'b0;
  bit   tb_inc = 1'b1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic [7:0] c, input int g, input int n,
                      input int dn);
    exp_t e;
    e.data = d;
    e.ctrl = c;
    e.gap  = g;
    e.cnt  = n;
    e.dn   = dn;
    exp_q.push_back(e);
  endtask

  task automatic push_start(input int g);
    push(START64, 8'h01, g, -1, -1);
  endtask

  task automatic push_data(input logic [63:0] d);
    push(d, 8'h00, -1, -1, -1);
  endtask

  task automatic push_term(input int n, input int dn);
    push(TERM64, 8'hFF, -1, n, dn);
  endtask

  // Wait until at most n expected beats remain, then step to the next negedge.
  task automatic wait_left(input int n, input int limit);
    int i = 0;
    while (exp_q.size() > n && i < limit) begin
      @(posedge clk);
      i++;
    end
    if (exp_q.size() > n) begin
      total++;
      bad++;
      $display("FAIL timeout: %0d beats outstanding, wanted %0d", exp_q.size(), n);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic start_test(input int idl, input int dl, input int md, input int pat,
                            input int mx);
    @(negedge clk);
    i_idle_len   = 16'(idl);
    i_data_len   = 16'(dl);
    i_mode       = 2'(md);
    i_pattern    = 8'(pat);
    i_max_frames = 32'(mx);
    tb_inc       = (md == 0) || (md == 3);
    i_enable     = 1'b1;
    i_rst        = 1'b1;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
  endtask

  always @(posedge clk) rst_edge <= i_rst;

  // Monitor for the 64-bit instance
  always @(negedge clk) begin
    if (rst_edge) begin
      idle_run = 0;
      chk("rst_data", 128'(tx_data64), 128'(IDLE64));
      chk("rst_ctrl", 128'(tx_ctrl64), 128'(8'hFF));
      chk("rst_count", 128'(fc64), 128'(0));
      chk("rst_done", 128'(done64), 128'(0));
    end else if (tx_ctrl64 == 8'hFF && tx_data64 == IDLE64) begin
      idle_run++;
    end else if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_beat: got %h/%h want idle", tx_data64, tx_ctrl64);
    end else begin
      mon_e = exp_q.pop_front();
      chk("beat_data", 128'(tx_data64), 128'(mon_e.data));
      chk("beat_ctrl", 128'(tx_ctrl64), 128'(mon_e.ctrl));
      if (mon_e.gap >= 0) chk("idle_gap", 128'(idle_run), 128'(mon_e.gap));
      if (mon_e.cnt >= 0) begin
        chk("frame_count", 128'(fc64), 128'(mon_e.cnt));
        chk("done", 128'(done64), 128'(mon_e.dn));
      end
      idle_run = 0;
    end
  end

  // Monitor for the 128-bit instance
  always @(negedge clk) begin
    if (rst_edge) begin
      first128 = 1'b0;
      chk("w_rst_data", tx_data128, IDLE128);
    end else if (tx_ctrl128 == 16'hFFFF) begin
      if (tx_data128[7:0] == 8'hFD) chk("w_term", tx_data128, TERM128);
      else chk("w_idle", tx_data128, IDLE128);
    end else if (tx_ctrl128 == 16'h0001) begin
      chk("w_start", tx_data128, START128);
      first128 = 1'b1;
    end else if (tx_ctrl128 == 16'h0000) begin
      if (first128 && tb_inc) chk("w_data0", tx_data128, DATA128_0);
      first128 = 1'b0;
    end else begin
      total++;
      bad++;
      $display("FAIL w_ctrl: got %h want a legal lane-control pattern", tx_ctrl128);
    end
  end

  initial begin
    // 1: basic frame, incrementing payload
    start_test(3, 2, 0, 0, 0);
    push_start(3);
    push_data(64'h0706050403020100);
    push_data(64'h0F0E0D0C0B0A0908);
    push_term(1, 0);
    wait_left(0, 200);
    i_enable = 1'b0;
    repeat (8) @(negedge clk);

    // 2: frame limit with zero lengths (treated as 1)
    start_test(0, 0, 0, 0, 3);
    for (int f = 1; f <= 3; f++) begin
      push_start(1);
      push_data(64'h0706050403020100);
      push_term(f, (f == 3) ? 1 : 0);
    end
    wait_left(0, 200);
    repeat (20) @(negedge clk);
    chk("limit_count", 128'(fc64), 128'(3));
    chk("limit_done", 128'(done64), 128'(1));

    // 3: fixed pattern; a mid-frame pattern change waits for the next frame
    start_test(3, 4, 1, 8'hA5, 0);
    push_start(3);
    repeat (4) push_data(64'hA5A5A5A5A5A5A5A5);
    push_term(1, 0);
    push_start(3);
    repeat (4) push_data(64'h3C3C3C3C3C3C3C3C);
    push_term(2, 0);
    wait_left(10, 200);
    i_pattern = 8'h3C;
    wait_left(0, 200);
    i_enable = 1'b0;
    repeat (8) @(negedge clk);

    // 4: LFSR payload continues across frames
    start_test(3, 2, 2, 0, 0);
    push_start(3);
    push_data(64'hFFFFFFFFFFFFFFFF);
    push_data(64'hFFFFFFFEFFFFFFFE);
    push_term(1, 0);
    push_start(3);
    push_data(64'hFFFFFFFDFFFFFFFD);
    push_data(64'hFFFFFFFBFFFFFFFB);
    push_term(2, 0);
    wait_left(0, 200);
    i_enable = 1'b0;
    repeat (8) @(negedge clk);

    // 5: enable dropped mid-frame; frame completes, then idle until re-raised
    start_test(3, 4, 1, 8'h11, 0);
    push_start(3);
    repeat (4) push_data(64'h1111111111111111);
    push_term(1, 0);
    wait_left(4, 200);
    i_enable = 1'b0;
    wait_left(0, 200);
    repeat (12) @(negedge clk);
    push_start(-1);
    repeat (4) push_data(64'h1111111111111111);
    push_term(2, 0);
    i_enable = 1'b1;
    wait_left(0, 200);
    i_enable = 1'b0;
    repeat (8) @(negedge clk);

    // 6: reset during payload truncates the frame (mode 3 behaves as mode 0)
    start_test(3, 4, 3, 0, 0);
    push_start(3);
    push_data(64'h0706050403020100);
    push_data(64'h0F0E0D0C0B0A0908);
    wait_left(1, 200);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    push_start(3);
    push_data(64'h0706050403020100);
    push_data(64'h0F0E0D0C0B0A0908);
    push_data(64'h1716151413121110);
    push_data(64'h1F1E1D1C1B1A1918);
    push_term(1, 0);
    wait_left(0, 200);
    i_enable = 1'b0;
    repeat (8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mii_frame_generator.md
Name: mii_frame_generator

Overview:
- Parametrised successor to the 1.6T MII traffic generator, for the same bring-up benches.
- Emits complete framed MII beats:
  - idle beats;
  - a start/preamble beat;
  - DATA_LEN payload beats;
  - a terminate beat.
- Control is per byte lane.
- Payload patterns are selectable at runtime, with optional frame-count limit and frame counter.
- Sits upstream of the PCS/encoder under test, driving its TX MII input.

Parameters:
- DATA_WIDTH, 64, MII data width in bits; multiple of 32, minimum 64. Lanes L = DATA_WIDTH/8; lane 0 = bits [7:0].
- LEN_WIDTH, 16, width of the runtime idle/data length inputs.
- CNT_WIDTH, 32, width of frame counter and frame limit.

Ports:
- clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_enable  in  1  1 = generate frames; 0 = finish current frame, then idle.
- i_idle_len  in  LEN_WIDTH  idle beats before each frame; 0 treated as 1.
- i_data_len  in  LEN_WIDTH  payload beats per frame; 0 treated as 1.
- i_mode  in  2  payload mode: 0 incrementing byte, 1 fixed pattern, 2 LFSR, 3 reserved (acts as 0).
- i_pattern  in  8  byte replicated on all lanes in mode 1.
- i_max_frames  in  CNT_WIDTH  0 = unlimited, else stop after this many frames.
- o_tx_data  out  DATA_WIDTH  MII data.
- o_tx_ctrl  out  DATA_WIDTH/8  per-lane control; 1 = control character.
- o_frame_count  out  CNT_WIDTH  frames completed (TERM beats emitted); saturates at all-ones.
- o_done  out  1  high once the frame limit is reached; sticky until reset.

Behaviour:
- Outputs are registered: beat for state S appears the cycle after S is entered.
- While i_rst = 1 or the cycle after reset:
  - o_tx_data = all lanes 0x07; o_tx_ctrl = all ones;
  - o_frame_count = 0; o_done = 0; state = IDLE; idle counter = 0.
- Beat encodings:
  - IDLE: every lane 0x07, ctrl all 1.
  - START: lane0 0xFB ctrl1; lanes 1..L-2 0x55 ctrl0; lane L-1 0xD5 ctrl0.
  - DATA: payload, ctrl all 0.
  - TERM: lane0 0xFD ctrl1; lanes 1..L-1 0x07 ctrl1.
- Config latch: i_idle_len, i_data_len, i_mode and i_pattern are sampled on entry to IDLE (reset exit and after each TERM) and held for that idle+frame. Mid-frame input changes are ignored.
- FSM transitions:
  - IDLE -> START when idle count reaches latched idle_len AND i_enable = 1 AND o_done = 0; otherwise stay IDLE (count saturates).
  - START -> DATA, always one beat.
  - DATA -> TERM after latched data_len DATA beats.
  - TERM -> IDLE; the idle counter restarts at 0.
  - TERM also increments o_frame_count (saturating).
  - If i_max_frames != 0 and the new count == i_max_frames, o_done is set in the same cycle as the count update.
  - After o_done: state stays IDLE and only idle beats are emitted.
- Lowering i_max_frames below the current count does not retroactively set o_done; o_done sets only on equality at a TERM.
- Enable handling: i_enable is only checked at the IDLE->START decision; a started frame always completes.
- Minimum spacing: with idle_len = 1 and data_len = 1, the period is IDLE, START, DATA, TERM = 4 beats.
- Payload mode 0 (incrementing byte):
  - An 8-bit byte counter resets to 0 at each START.
  - Lane k of a DATA beat = counter + k (mod 256); the counter advances by L per beat, wrapping mod 256.
- Payload mode 1 (fixed): i_pattern (latched value) on every lane.
- Payload mode 2 (LFSR):
  - 32-bit Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1, seeded 0xFFFFFFFF at reset.
  - Not reseeded per frame; advances one step per DATA beat only.
  - Each 32-bit slice of o_tx_data = current LFSR value.
- Reset mid-frame: the next cycle outputs an IDLE beat. No TERM is emitted; the counter is not incremented; the frame is simply truncated.

Test Plan:
- Reset, L=8, idle_len=3, data_len=2, mode 0, enable=1, max=0:
  - 3 idle beats (0x0707070707070707, ctrl 0xFF);
  - START 0xD5555555555555FB, ctrl 0x01;
  - DATA 0x0706050403020100, then 0x0F0E0D0C0B0A0908, ctrl 0x00;
  - TERM 0x07070707070707FD, ctrl 0xFF;
  - o_frame_count = 1.
- max_frames=3, idle_len=0, data_len=0:
  - exactly 3 frames of 4 beats each;
  - o_done rises with the 3rd count update;
  - idle beats forever after; count stays 3.
- mode 1, pattern 0xA5, data_len=4:
  - 4 DATA beats of 0xA5A5A5A5A5A5A5A5;
  - change i_pattern mid-frame to 0x3C: no effect until after the next TERM.
- mode 2, data_len=2:
  - first DATA = 0xFFFFFFFFFFFFFFFF;
  - second DATA = LFSR step 1 in both halves;
  - the next frame continues the sequence (no reseed).
- Drop i_enable during DATA:
  - frame completes with TERM;
  - generator stays idle;
  - re-raise: START follows after the latched idle_len.
- Assert i_rst during DATA for 1 cycle: next beat is idle, count unchanged, the idle gap restarts; repeat with DATA_WIDTH=128 to check preamble lane 15 = 0xD5.
